// File: rtl/rect_pkg.sv
// Shared types for the rectangle corner-swap engine.
// Result codes, FSM states and the matrix bit-index helper.
package rect_pkg;

  typedef enum logic [1:0] {
    SWAPPED    = 2'd0,
    DEGENERATE = 2'd1,
    RANGE      = 2'd2,
    PATTERN    = 2'd3
  } resp_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Row 0 / column 0 sits at the MSB of the flattened matrix.
  function automatic int idx(
    input int r,
    input int c,
    input int rows,
    input int cols
  );
    return rows * cols - 1 - (r * cols + c);
  endfunction

endpackage

// File: rtl/rect_corner_mask.sv
// Combinational one-hot masks for the four rectangle corners.
// Out-of-range coordinates simply produce an empty mask.
module rect_corner_mask
  import rect_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = 2,
  parameter int CW   = 2
) (
  input  logic [RW-1:0]        r1,
  input  logic [RW-1:0]        r2,
  input  logic [CW-1:0]        c1,
  input  logic [CW-1:0]        c2,
  output logic [ROWS*COLS-1:0] m_a,
  output logic [ROWS*COLS-1:0] m_b,
  output logic [ROWS*COLS-1:0] m_e,
  output logic [ROWS*COLS-1:0] m_d,
  output logic [ROWS*COLS-1:0] m_all
);

  always_comb begin
    m_a = '0;
    m_b = '0;
    m_e = '0;
    m_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r1 == RW'(r) && c1 == CW'(c))
          m_a[idx(r, c, ROWS, COLS)] = 1'b1;
        if (r1 == RW'(r) && c2 == CW'(c))
          m_b[idx(r, c, ROWS, COLS)] = 1'b1;
        if (r2 == RW'(r) && c1 == CW'(c))
          m_e[idx(r, c, ROWS, COLS)] = 1'b1;
        if (r2 == RW'(r) && c2 == CW'(c))
          m_d[idx(r, c, ROWS, COLS)] = 1'b1;
      end
    end
  end

  assign m_all = m_a | m_b | m_e | m_d;

endmodule

// File: rtl/rect_swap_engine.sv
// Binary matrix holder that flips checkerboard rectangle corners,
// keeping every row and column sum intact.
module rect_swap_engine
  import rect_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int RW    = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS),
  parameter int CW    = ($clog2(COLS) < 1) ? 1 : $clog2(COLS),
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] m_load,
  output logic                 load_ready,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [RW-1:0]        r1,
  input  logic [RW-1:0]        r2,
  input  logic [CW-1:0]        c1,
  input  logic [CW-1:0]        c2,
  output logic                 resp_valid,
  output logic [1:0]           resp_code,
  output logic [ROWS*COLS-1:0] m_out,
  output logic                 busy,
  output logic [CNT_W-1:0]     swap_cnt,
  output logic [CNT_W-1:0]     rej_cnt
);

  localparam int N = ROWS * COLS;

  state_t        state;
  resp_code_t    dec_q;
  resp_code_t    code_q;
  resp_code_t    chk;
  logic [N-1:0]  m;
  logic [N-1:0]  mask_q;
  logic [RW-1:0] q_r1;
  logic [RW-1:0] q_r2;
  logic [CW-1:0] q_c1;
  logic [CW-1:0] q_c2;
  logic [N-1:0]  k_a;
  logic [N-1:0]  k_b;
  logic [N-1:0]  k_e;
  logic [N-1:0]  k_d;
  logic [N-1:0]  k_all;
  logic          v_a;
  logic          v_b;
  logic          v_e;
  logic          v_d;
  logic          oor;
  logic          degen;

  rect_corner_mask #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_mask (
    .r1    (q_r1),
    .r2    (q_r2),
    .c1    (q_c1),
    .c2    (q_c2),
    .m_a   (k_a),
    .m_b   (k_b),
    .m_e   (k_e),
    .m_d   (k_d),
    .m_all (k_all)
  );

  assign v_a = |(m & k_a);
  assign v_b = |(m & k_b);
  assign v_e = |(m & k_e);
  assign v_d = |(m & k_d);

  assign oor = (int'(q_r1) >= ROWS) ||
               (int'(q_r2) >= ROWS) ||
               (int'(q_c1) >= COLS) ||
               (int'(q_c2) >= COLS);

  assign degen = (q_r1 == q_r2) || (q_c1 == q_c2);

  // First match wins: range, then degenerate, then pattern.
  always_comb begin
    chk = SWAPPED;
    if (oor)
      chk = RANGE;
    else if (degen)
      chk = DEGENERATE;
    else if (v_a != v_d || v_b != v_e || v_a == v_b)
      chk = PATTERN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m          <= '0;
      mask_q     <= '0;
      dec_q      <= SWAPPED;
      code_q     <= SWAPPED;
      resp_valid <= 1'b0;
      swap_cnt   <= '0;
      rej_cnt    <= '0;
      q_r1       <= '0;
      q_r2       <= '0;
      q_c1       <= '0;
      q_c2       <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            m <= m_load;
          end else if (req_valid) begin
            q_r1  <= r1;
            q_r2  <= r2;
            q_c1  <= c1;
            q_c2  <= c2;
            state <= CHECK;
          end
        end
        CHECK: begin
          dec_q  <= chk;
          mask_q <= k_all;
          state  <= APPLY;
        end
        APPLY: begin
          if (dec_q == SWAPPED) begin
            m <= m ^ mask_q;
            if (swap_cnt != '1)
              swap_cnt <= swap_cnt + 1'b1;
          end else if (rej_cnt != '1) begin
            rej_cnt <= rej_cnt + 1'b1;
          end
          resp_valid <= 1'b1;
          code_q     <= dec_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_out      = m;
  assign resp_code  = code_q;
  assign busy       = (state != IDLE);
  assign load_ready = (state == IDLE);
  assign req_ready  = (state == IDLE) && !load_valid;

endmodule

// File: tb/tb_rect_swap_engine.sv
// Randomised bench for rect_swap_engine with a matrix-level model.
// Three builds: 4x4, 3x3 with 2-bit counters, and 8x8.
module tb_rect_swap_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        lv;
  logic        rv;
  logic [63:0] ml;
  logic [2:0]  r1, r2, c1, c2;
  int          sel;

  always #5 clk = ~clk;

  logic        lr4, rr4, vv4, bz4;
  logic        lr3, rr3, vv3, bz3;
  logic        lr8, rr8, vv8, bz8;
  logic [1:0]  cd4, cd3, cd8;
  logic [15:0] m4;
  logic [8:0]  m3;
  logic [63:0] m8;
  logic [15:0] sc4, rc4, sc8, rc8;
  logic [1:0]  sc3, rc3;

  rect_swap_engine dut4 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv && sel == 0),
    .m_load     (ml[15:0]),
    .load_ready (lr4),
    .req_valid  (rv && sel == 0),
    .req_ready  (rr4),
    .r1         (r1[1:0]),
    .r2         (r2[1:0]),
    .c1         (c1[1:0]),
    .c2         (c2[1:0]),
    .resp_valid (vv4),
    .resp_code  (cd4),
    .m_out      (m4),
    .busy       (bz4),
    .swap_cnt   (sc4),
    .rej_cnt    (rc4)
  );

  rect_swap_engine #(
    .ROWS  (3),
    .COLS  (3),
    .CNT_W (2)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv && sel == 1),
    .m_load     (ml[8:0]),
    .load_ready (lr3),
    .req_valid  (rv && sel == 1),
    .req_ready  (rr3),
    .r1         (r1[1:0]),
    .r2         (r2[1:0]),
    .c1         (c1[1:0]),
    .c2         (c2[1:0]),
    .resp_valid (vv3),
    .resp_code  (cd3),
    .m_out      (m3),
    .busy       (bz3),
    .swap_cnt   (sc3),
    .rej_cnt    (rc3)
  );

  rect_swap_engine #(
    .ROWS (8),
    .COLS (8)
  ) dut8 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv && sel == 2),
    .m_load     (ml),
    .load_ready (lr8),
    .req_valid  (rv && sel == 2),
    .req_ready  (rr8),
    .r1         (r1),
    .r2         (r2),
    .c1         (c1),
    .c2         (c2),
    .resp_valid (vv8),
    .resp_code  (cd8),
    .m_out      (m8),
    .busy       (bz8),
    .swap_cnt   (sc8),
    .rej_cnt    (rc8)
  );

  logic        o_lr, o_rr, o_rv, o_bz;
  logic [1:0]  o_code;
  logic [63:0] o_m;
  logic [15:0] o_sc, o_rc;

  always_comb begin
    o_lr   = lr4;
    o_rr   = rr4;
    o_rv   = vv4;
    o_bz   = bz4;
    o_code = cd4;
    o_m    = {48'd0, m4};
    o_sc   = sc4;
    o_rc   = rc4;
    if (sel == 1) begin
      o_lr   = lr3;
      o_rr   = rr3;
      o_rv   = vv3;
      o_bz   = bz3;
      o_code = cd3;
      o_m    = {55'd0, m3};
      o_sc   = {14'd0, sc3};
      o_rc   = {14'd0, rc3};
    end else if (sel == 2) begin
      o_lr   = lr8;
      o_rr   = rr8;
      o_rv   = vv8;
      o_bz   = bz8;
      o_code = cd8;
      o_m    = m8;
      o_sc   = sc8;
      o_rc   = rc8;
    end
  end

  // Reference model: one matrix and two counters per build.
  logic [63:0] mm [3];
  int          sc [3];
  int          rcn [3];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic int rows_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 3 : 8;
  endfunction

  function automatic int cmax(input int s);
    return (s == 1) ? 3 : 65535;
  endfunction

  function automatic logic [63:0] fmask(input int s);
    logic [63:0] one = 64'd1;
    int n = rows_of(s) * rows_of(s);
    return (one << n) - 64'd1;
  endfunction

  function automatic int pos(input int s, input int r, input int c);
    int n = rows_of(s);
    return n * n - 1 - (r * n + c);
  endfunction

  function automatic logic el(
    input logic [63:0] m, input int s, input int r, input int c
  );
    return m[pos(s, r, c)];
  endfunction

  function automatic logic [1:0] ref_code(
    input logic [63:0] m, input int s,
    input int a1, input int a2, input int b1, input int b2
  );
    int n = rows_of(s);
    if (a1 >= n || a2 >= n || b1 >= n || b2 >= n) return 2'd2;
    if (a1 == a2 || b1 == b2) return 2'd1;
    if (el(m, s, a1, b1) == el(m, s, a2, b2) &&
        el(m, s, a1, b2) == el(m, s, a2, b1) &&
        el(m, s, a1, b1) != el(m, s, a1, b2))
      return 2'd0;
    return 2'd3;
  endfunction

  function automatic int line_sum(
    input logic [63:0] m, input int s, input int k, input bit col
  );
    int t = 0;
    for (int j = 0; j < rows_of(s); j++)
      t += col ? int'(el(m, s, j, k)) : int'(el(m, s, k, j));
    return t;
  endfunction

  task automatic reset_model();
    for (int s = 0; s < 3; s++) begin
      mm[s]  = '0;
      sc[s]  = 0;
      rcn[s] = 0;
    end
  endtask

  task automatic do_load(input logic [63:0] v);
    @(negedge clk);
    lv = 1'b1;
    ml = v;
    @(negedge clk);
    lv = 1'b0;
    mm[sel] = v & fmask(sel);
    n_cmp++;
    if (o_m !== mm[sel]) begin
      n_err++;
      $display("FAIL load m_out got %h want %h", o_m, mm[sel]);
    end
  endtask

  // Request already presented with ready high; handshake at next edge.
  task automatic run_req(input string nm);
    int s = sel;
    logic [1:0] exp;
    logic [63:0] t;
    exp = ref_code(mm[s], s, r1, r2, c1, c2);
    if (exp == 2'd0) begin
      t = mm[s];
      t[pos(s, r1, c1)] = ~t[pos(s, r1, c1)];
      t[pos(s, r1, c2)] = ~t[pos(s, r1, c2)];
      t[pos(s, r2, c1)] = ~t[pos(s, r2, c1)];
      t[pos(s, r2, c2)] = ~t[pos(s, r2, c2)];
      mm[s] = t;
      if (sc[s] < cmax(s)) sc[s]++;
    end else if (rcn[s] < cmax(s)) begin
      rcn[s]++;
    end
    @(posedge clk);
    @(negedge clk);
    rv = 1'b0;
    n_cmp++;
    if (o_bz !== 1'b1 || o_rv !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy/resp in CHECK got %b/%b want 1/0",
               nm, o_bz, o_rv);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (o_rv !== 1'b1 || o_code !== exp) begin
      n_err++;
      $display("FAIL %s resp got v=%b code=%0d want v=1 code=%0d",
               nm, o_rv, o_code, exp);
    end
    n_cmp++;
    if (o_m !== mm[s]) begin
      n_err++;
      $display("FAIL %s m_out got %h want %h", nm, o_m, mm[s]);
    end
    n_cmp++;
    if (o_sc !== 16'(sc[s]) || o_rc !== 16'(rcn[s])) begin
      n_err++;
      $display("FAIL %s counters got %0d/%0d want %0d/%0d",
               nm, o_sc, o_rc, sc[s], rcn[s]);
    end
    n_cmp++;
    if (o_rr !== 1'b1 || o_bz !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready after resp got rdy=%b busy=%b want 1/0",
               nm, o_rr, o_bz);
    end
  endtask

  task automatic do_req(
    input int a1, input int a2, input int b1, input int b2,
    input string nm
  );
    int k = 0;
    @(negedge clk);
    r1 = 3'(a1);
    r2 = 3'(a2);
    c1 = 3'(b1);
    c2 = 3'(b2);
    rv = 1'b1;
    #1;
    while (!o_rr && k < 5) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!o_rr) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s req_ready timeout got 0 want 1", nm);
      rv = 1'b0;
    end else begin
      run_req(nm);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    lv  = 1'b0;
    rv  = 1'b0;
    ml  = '0;
    r1  = '0;
    r2  = '0;
    c1  = '0;
    c2  = '0;
    reset_model();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (o_m !== 64'd0 || o_bz !== 1'b0 || o_rv !== 1'b0 ||
        o_code !== 2'd0) begin
      n_err++;
      $display("FAIL reset state got m=%h busy=%b v=%b code=%0d want 0",
               o_m, o_bz, o_rv, o_code);
    end
    n_cmp++;
    if (o_sc !== 16'd0 || o_rc !== 16'd0 ||
        o_lr !== 1'b1 || o_rr !== 1'b1) begin
      n_err++;
      $display("FAIL reset cnt/ready got %0d/%0d lr=%b rr=%b want 0/0/1/1",
               o_sc, o_rc, o_lr, o_rr);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    sel = 0;
    do_load(64'h8400);
    do_req(0, 1, 0, 1, "swap_8400");
    do_load(64'hC000);
    do_req(0, 1, 0, 1, "pattern_c000");
    do_load(64'h4800);
    do_req(1, 0, 1, 0, "swap_rev_4800");
    do_req(2, 2, 0, 3, "degenerate_row");
    do_req(1, 3, 2, 2, "degenerate_col");
  endtask

  task automatic test_load_priority();
    sel = 0;
    @(negedge clk);
    lv = 1'b1;
    ml = 64'h8400;
    rv = 1'b1;
    r1 = 3'd0;
    r2 = 3'd1;
    c1 = 3'd0;
    c2 = 3'd1;
    #1;
    n_cmp++;
    if (o_rr !== 1'b0 || o_lr !== 1'b1) begin
      n_err++;
      $display("FAIL prio ready got rr=%b lr=%b want 0/1", o_rr, o_lr);
    end
    @(negedge clk);
    lv = 1'b0;
    mm[0] = 64'h8400;
    #1;
    n_cmp++;
    if (o_m !== 64'h8400 || o_rr !== 1'b1 || o_bz !== 1'b0) begin
      n_err++;
      $display("FAIL prio load got m=%h rr=%b busy=%b want 8400/1/0",
               o_m, o_rr, o_bz);
    end
    run_req("prio_req");
  endtask

  task automatic test_load_while_busy();
    sel = 0;
    do_load(64'h8400);
    @(negedge clk);
    r1 = 3'd0;
    r2 = 3'd1;
    c1 = 3'd0;
    c2 = 3'd1;
    rv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv = 1'b0;
    lv = 1'b1;
    ml = 64'hFFFF;
    n_cmp++;
    if (o_lr !== 1'b0) begin
      n_err++;
      $display("FAIL busy load_ready got %b want 0", o_lr);
    end
    @(negedge clk);
    @(negedge clk);
    lv = 1'b0;
    mm[0] = 64'h4800;
    sc[0]++;
    n_cmp++;
    if (o_m !== 64'h4800 || o_code !== 2'd0 || o_rv !== 1'b1) begin
      n_err++;
      $display("FAIL busy load ignored got m=%h code=%0d v=%b want 4800/0/1",
               o_m, o_code, o_rv);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(negedge clk);
    r1 = 3'd1;
    r2 = 3'd0;
    c1 = 3'd1;
    c2 = 3'd0;
    rv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    reset_model();
    n_cmp++;
    if (o_rv !== 1'b0 || o_m !== 64'd0 || o_bz !== 1'b0 ||
        o_sc !== 16'd0 || o_rc !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b m=%h busy=%b cnt=%0d/%0d want 0",
               o_rv, o_m, o_bz, o_sc, o_rc);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (o_rv !== 1'b0 || o_m !== 64'd0) begin
      n_err++;
      $display("FAIL mid_reset late resp got v=%b m=%h want 0/0",
               o_rv, o_m);
    end
  endtask

  task automatic test_random4();
    sel = 0;
    for (int i = 0; i < 24; i++) begin
      do_load(64'($urandom_range(0, 65535)));
      do_req($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), "rand4");
    end
  endtask

  task automatic test_range3();
    sel = 1;
    do_load(64'h1AA);
    do_req(0, 3, 1, 1, "range_r2_degen_c");
    do_req(0, 1, 0, 3, "range_c2");
    do_req(3, 3, 0, 1, "range_r1r2");
    do_req(1, 1, 0, 2, "degen_rej_sat");
  endtask

  task automatic test_saturate();
    sel = 1;
    do_load(64'h110);
    for (int i = 0; i < 5; i++)
      do_req(0, 1, 0, 1, "sat_swap");
    n_cmp++;
    if (o_sc !== 16'd3) begin
      n_err++;
      $display("FAIL swap_cnt saturate got %0d want 3", o_sc);
    end
  endtask

  task automatic test_random8();
    logic [63:0] v, pre;
    int a1, a2, b1, b2;
    bit x;
    sel = 2;
    for (int i = 0; i < 30; i++) begin
      v  = {$urandom, $urandom};
      a1 = $urandom_range(0, 7);
      a2 = (a1 + $urandom_range(1, 7)) % 8;
      b1 = $urandom_range(0, 7);
      b2 = (b1 + $urandom_range(1, 7)) % 8;
      x  = 1'($urandom);
      v[pos(2, a1, b1)] = x;
      v[pos(2, a2, b2)] = x;
      v[pos(2, a1, b2)] = ~x;
      v[pos(2, a2, b1)] = ~x;
      do_load(v);
      pre = mm[2];
      do_req(a1, a2, b1, b2, "rand8");
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (line_sum(o_m, 2, k, 1'b0) != line_sum(pre, 2, k, 1'b0) ||
            line_sum(o_m, 2, k, 1'b1) != line_sum(pre, 2, k, 1'b1)) begin
          n_err++;
          $display("FAIL rand8 sums line %0d got r=%0d c=%0d want r=%0d c=%0d",
                   k, line_sum(o_m, 2, k, 1'b0), line_sum(o_m, 2, k, 1'b1),
                   line_sum(pre, 2, k, 1'b0), line_sum(pre, 2, k, 1'b1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_priority();
    test_load_while_busy();
    test_reset_mid();
    test_random4();
    test_range3();
    test_saturate();
    test_random8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rect_swap_engine.md
# rect_swap_engine

Parametrised successor to the four-corner flip block in the Rectangle Loop datapath. The block holds a ROWS×COLS binary matrix in an internal register and accepts rectangle requests (r1, r2, c1, c2) over a valid/ready handshake. It flips the four corners only when they form a checkerboard, which preserves every row sum and column sum. Degenerate, out-of-range and non-checkerboard requests are rejected and the matrix is left unchanged. Each request returns a one-cycle response with a result code, and the block keeps saturating swap and reject counters.

## Interface
- ROWS, 4: matrix rows (≥2)
- COLS, 4: matrix columns (≥2)
- RW, $clog2(ROWS) (min 1): row-index width
- CW, $clog2(COLS) (min 1): column-index width
- CNT_W, 16: statistics counter width
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- load_valid  in  1  load m_load into the matrix
- m_load  in  ROWS*COLS  matrix to load
- load_ready  out  1  high in IDLE
- req_valid  in  1  rectangle request valid
- req_ready  out  1  = IDLE && !load_valid
- r1, r2  in  RW  corner rows
- c1, c2  in  CW  corner columns
- resp_valid  out  1  one-cycle result pulse
- resp_code  out  2  result: 0 SWAPPED, 1 DEGENERATE, 2 RANGE, 3 PATTERN
- m_out  out  ROWS*COLS  current matrix
- busy  out  1  state != IDLE
- swap_cnt, rej_cnt  out  CNT_W  accepted and rejected request counts

## Operation
- Bit mapping: element (r,c) is at bit ROWS*COLS-1-(r*COLS+c). Row 0 / column 0 is the MSB.
- FSM states:
  - IDLE: on load_valid, m ← m_load and the state stays IDLE. Else on req_valid&&req_ready, latch the coordinates and go to CHECK.
  - CHECK: read the four corners and register the decision and mask. Go to APPLY.
  - APPLY: if the decision is SWAPPED, m ← m ^ mask. Update one counter, drive resp_valid/resp_code, and go to IDLE.
- Decision priority, first match wins:
  - RANGE: r1 or r2 ≥ ROWS, or c1 or c2 ≥ COLS. Reachable only for non-power-of-2 dimensions.
  - DEGENERATE: r1==r2 or c1==c2.
  - PATTERN: the corners are not a checkerboard. A checkerboard requires a=(r1,c1) == d=(r2,c2), b=(r1,c2) == e=(r2,c1), and a != b.
  - SWAPPED: otherwise.
- Swapped coordinate order (r2<r1 or c2<c1) is legal and must give the same result as the sorted order.
- Counters saturate at 2^CNT_W−1. swap_cnt counts SWAPPED responses; rej_cnt counts all other codes.
- Load has priority over a request in the same IDLE cycle. Loads are ignored outside IDLE (load_ready=0).

## Timing
- Reset values: m_out=0, state=IDLE, resp_valid=0, resp_code=0, swap_cnt=0, rej_cnt=0, busy=0. Consequently load_ready=1 and req_ready=1 during and after reset, unless load_valid is high.
- Reset mid-operation (CHECK/APPLY): the request is dropped, no response is issued, the matrix is cleared, and the state returns to IDLE.
- Let E0 be the handshake edge:
  - E1: CHECK register updated.
  - E2: m_out and counters updated; resp_valid is high for the single cycle after E2.
  - req_ready is high again in the cycle after E2.
- Throughput: one request per 3 cycles. No response back-pressure.
- Load: m_out reflects m_load in the cycle after the load edge.
- m_out is registered only and never combinationally depends on inputs.

## Structure
- rect_pkg holds:
  - resp_code_t enum {SWAPPED, DEGENERATE, RANGE, PATTERN}
  - state_t enum {IDLE, CHECK, APPLY}
  - bit-index function idx(r,c)
- Sub-module rect_corner_mask: combinational. Inputs are the coordinates; outputs are the four corner one-hot masks and their OR. It is reused by the checker and the flip path.
- Expected size: ~150–250 lines of RTL.

## Test plan
- 4×4: load 16'h8400, request (0,1,0,1) → resp_code SWAPPED at E2+1, m_out=16'h4800, swap_cnt=1.
- Load 16'hC000, request (0,1,0,1) → PATTERN, m_out stays 16'hC000, rej_cnt=1. Request (1,0,1,0) on 16'h4800 → SWAPPED, m_out=16'h8400.
- Request r1=r2=2 → DEGENERATE, matrix unchanged. ROWS=3, COLS=3 build: r2=3 → RANGE even when c1==c2.
- load_valid and req_valid high together in IDLE → load taken, req_ready=0. The request is accepted the next cycle if it is still valid.
- Assert rst in CHECK → no resp_valid, m_out=0, busy=0 the next cycle, counters 0.
- CNT_W=2: five SWAPPED requests → swap_cnt saturates at 3. Random legal swaps on 8×8 → the scoreboard checks that row and column sums are preserved after every response.
